window_kxk: RTL and testbench

WINDOW_KXK -- requirements
Module: window_kxk

---
 rtl/window_pkg.sv | 18 +
 rtl/window_kxk_if.sv | 26 ++
 rtl/line_delay.sv | 37 +++
 rtl/window_kxk.sv | 116 +++++++++++
 tb/tb_window_kxk.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/window_pkg.sv
// Shared helpers for the KxK sliding-window block: counter widths and
// elaboration-time parameter checks.
package window_pkg;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

    function automatic bit win_ok(input int win, input int width, input int height);
        return (win >= 3) && (win <= 9) && (win % 2 == 1) && (width >= win) && (height >= win);
    endfunction

endpackage

// File: rtl/window_kxk_if.sv
// Pixel-stream bundle for window_kxk: raster input side and window output side.
interface window_kxk_if #(
    parameter int DW  = 8,
    parameter int WIN = 7,
    parameter int XW  = 10,
    parameter int YW  = 9
);
    logic [DW-1:0]         din;
    logic                  din_valid;
    logic                  sof;
    logic [WIN*WIN*DW-1:0] win_o;
    logic                  dout_valid;
    logic [XW-1:0]         x_o;
    logic [YW-1:0]         y_o;
    logic                  frame_done;

    modport master (
        output din, din_valid, sof,
        input  win_o, dout_valid, x_o, y_o, frame_done
    );

    modport slave (
        input  din, din_valid, sof,
        output win_o, dout_valid, x_o, y_o, frame_done
    );
endinterface

// File: rtl/line_delay.sv
// One image line of delay: a DEPTH-entry RAM addressed by a wrapping pointer
// that only moves on accepted pixels, so dout is the pixel DEPTH accepts ago.
module line_delay
    import window_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 640
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    localparam int AW = clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         addr_q, addr_d;

    // read-before-write on the same slot: the old entry leaves as the new one lands
    assign dout = mem_q[addr_q];

    always_comb begin
        addr_d = addr_q;
        if (en) addr_d = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) addr_q <= '0;
        else     addr_q <= addr_d;
    end

    always_ff @(posedge clk) begin
        if (en) mem_q[addr_q] <= din;
    end

endmodule

// File: rtl/window_kxk.sv
// KxK sliding window over a raster pixel stream with one cycle of latency;
// validity and centre coordinates come straight from the column/row counters.
module window_kxk
    import window_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int WIN          = 7
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           din,
    input  logic                            din_valid,
    input  logic                            sof,
    output logic [WIN*WIN*DATA_WIDTH-1:0]   win_o,
    output logic                            dout_valid,
    output logic [clog2(IMAGE_WIDTH)-1:0]   x_o,
    output logic [clog2(IMAGE_HEIGHT)-1:0]  y_o,
    output logic                            frame_done
);
    localparam int XW   = clog2(IMAGE_WIDTH);
    localparam int YW   = clog2(IMAGE_HEIGHT);
    localparam int HALF = (WIN - 1) / 2;

    if (!win_ok(WIN, IMAGE_WIDTH, IMAGE_HEIGHT)) begin : g_bad_win
        $error("window_kxk: WIN must be odd in 3..9 and fit the image");
    end

    logic                                  en;
    logic [WIN-2:0][DATA_WIDTH-1:0]        ld_in, ld_out;
    logic [WIN-1:0][DATA_WIDTH-1:0]        col_in;
    logic [WIN-1:0][WIN-1:0][DATA_WIDTH-1:0] win_q, win_d;
    logic [XW-1:0] col_cnt_q, col_cnt_d, cur_col, x_q, x_d;
    logic [YW-1:0] row_cnt_q, row_cnt_d, cur_row, y_q, y_d;
    logic          dout_valid_q, dout_valid_d, frame_done_q, frame_done_d;

    assign en = din_valid & ~rst;

    for (genvar k = 0; k < WIN - 1; k++) begin : g_ld
        if (k == 0) begin : g_head
            assign ld_in[k] = din;
        end else begin : g_chain
            assign ld_in[k] = ld_out[k-1];
        end
        line_delay #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMAGE_WIDTH)) u_ld (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .din  (ld_in[k]),
            .dout (ld_out[k])
        );
    end

    always_comb begin
        col_in          = '0;
        col_in[WIN-1]   = din;
        for (int k = 0; k < WIN - 1; k++) col_in[WIN-2-k] = ld_out[k];
    end

    always_comb begin
        // sof forces the accepted pixel to (0,0) whatever the counters hold
        cur_col      = sof ? '0 : col_cnt_q;
        cur_row      = sof ? '0 : row_cnt_q;
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        win_d        = win_q;
        x_d          = x_q;
        y_d          = y_q;
        dout_valid_d = 1'b0;
        frame_done_d = 1'b0;
        if (din_valid) begin
            if (cur_col == XW'(IMAGE_WIDTH - 1)) begin
                col_cnt_d = '0;
                row_cnt_d = (cur_row == YW'(IMAGE_HEIGHT - 1)) ? '0 : cur_row + YW'(1);
            end else begin
                col_cnt_d = cur_col + XW'(1);
                row_cnt_d = cur_row;
            end
            for (int r = 0; r < WIN; r++) win_d[r] = {col_in[r], win_q[r][WIN-1:1]};
            dout_valid_d = (cur_row >= YW'(WIN - 1)) && (cur_col >= XW'(WIN - 1));
            frame_done_d = (cur_row == YW'(IMAGE_HEIGHT - 1)) && (cur_col == XW'(IMAGE_WIDTH - 1));
            if (dout_valid_d) begin
                x_d = cur_col - XW'(HALF);
                y_d = cur_row - YW'(HALF);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            win_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            dout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            win_q        <= win_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dout_valid_q <= dout_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_o      = win_q;
    assign x_o        = x_q;
    assign y_o        = y_q;
    assign dout_valid = dout_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_kxk.sv
// Directed bench: 3x3 window on a 4x4 frame (continuous, gapped, sof abort,
// mid-frame reset) and a 7x7 window on a 32x24 ramp.
module tb_window_kxk;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    window_kxk_if #(.DW(8),  .WIN(3), .XW(2), .YW(2)) ifa ();
    window_kxk_if #(.DW(16), .WIN(7), .XW(5), .YW(5)) ifb ();

    window_kxk #(.DATA_WIDTH(8), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .WIN(3)) dut_a (
        .clk(clk), .rst(rst), .din(ifa.din), .din_valid(ifa.din_valid), .sof(ifa.sof),
        .win_o(ifa.win_o), .dout_valid(ifa.dout_valid), .x_o(ifa.x_o), .y_o(ifa.y_o),
        .frame_done(ifa.frame_done)
    );

    window_kxk #(.DATA_WIDTH(16), .IMAGE_WIDTH(32), .IMAGE_HEIGHT(24), .WIN(7)) dut_b (
        .clk(clk), .rst(rst), .din(ifb.din), .din_valid(ifb.din_valid), .sof(ifb.sof),
        .win_o(ifb.win_o), .dout_valid(ifb.dout_valid), .x_o(ifb.x_o), .y_o(ifb.y_o),
        .frame_done(ifb.frame_done)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] win_a(input int base, input int rr, input int cc);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3+c)*8 +: 8] = 8'(base + (rr - 2 + r) * 4 + (cc - 2 + c));
        return w;
    endfunction

    task automatic frame_a(input int base, input bit gaps, input bit first_sof,
                           output int pulses, output int dones);
        pulses = 0;
        dones  = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ifa.din       = 8'(base + r * 4 + c);
                ifa.din_valid = 1'b1;
                ifa.sof       = first_sof && (r == 0) && (c == 0);
                tick();
                pulses += int'(ifa.dout_valid);
                dones  += int'(ifa.frame_done);
                chk("a_dv", ifa.dout_valid, (r >= 2) && (c >= 2));
                chk("a_fd", ifa.frame_done, (r == 3) && (c == 3));
                if (r >= 2 && c >= 2) begin
                    chk("a_win", ifa.win_o, win_a(base, r, c));
                    chk("a_x", ifa.x_o, c - 1);
                    chk("a_y", ifa.y_o, r - 1);
                end
                if (base == 0 && r == 2 && c == 2)
                    chk("a_first_win", ifa.win_o, 72'h0a_09_08_06_05_04_02_01_00);
                if (gaps) begin
                    ifa.din_valid = 1'b0;
                    ifa.sof       = 1'b1;
                    ifa.din       = 8'hA5;
                    tick();
                    pulses += int'(ifa.dout_valid);
                    dones  += int'(ifa.frame_done);
                    chk("gap_dv", ifa.dout_valid, 1'b0);
                    chk("gap_fd", ifa.frame_done, 1'b0);
                    if (r >= 2 && c >= 2) begin
                        chk("gap_win", ifa.win_o, win_a(base, r, c));
                        chk("gap_x", ifa.x_o, c - 1);
                        chk("gap_y", ifa.y_o, r - 1);
                    end
                end
            end
        end
        ifa.din_valid = 1'b0;
        ifa.sof       = 1'b0;
    endtask

    task automatic partial_a(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            ifa.din       = 8'(base + i);
            ifa.din_valid = 1'b1;
            ifa.sof       = (i == 0);
            tick();
            chk("part_dv", ifa.dout_valid, 1'b0);
            chk("part_fd", ifa.frame_done, 1'b0);
        end
        ifa.din_valid = 1'b0;
        ifa.sof       = 1'b0;
    endtask

    task automatic frame_b(output int pulses, output int dones);
        pulses = 0;
        dones  = 0;
        for (int r = 0; r < 24; r++) begin
            for (int c = 0; c < 32; c++) begin
                ifb.din       = 16'(r * 32 + c);
                ifb.din_valid = 1'b1;
                ifb.sof       = (r == 0) && (c == 0);
                tick();
                pulses += int'(ifb.dout_valid);
                dones  += int'(ifb.frame_done);
                chk("b_dv", ifb.dout_valid, (r >= 6) && (c >= 6));
                chk("b_fd", ifb.frame_done, (r == 23) && (c == 31));
                if (r >= 6 && c >= 6) begin
                    chk("b_centre", ifb.win_o[(3*7+3)*16 +: 16], (r - 3) * 32 + (c - 3));
                    chk("b_corner", ifb.win_o[0 +: 16], (r - 6) * 32 + (c - 6));
                    chk("b_x", ifb.x_o, c - 3);
                    chk("b_y", ifb.y_o, r - 3);
                end
                if (r == 6 && c == 6) begin
                    for (int wr = 0; wr < 7; wr++)
                        for (int wc = 0; wc < 7; wc++)
                            chk("b_first_win", ifb.win_o[(wr*7+wc)*16 +: 16], wr * 32 + wc);
                end
            end
        end
        ifb.din_valid = 1'b0;
        ifb.sof       = 1'b0;
    endtask

    initial begin
        int p, d;
        rst = 1'b1;
        ifa.din = '0; ifa.din_valid = 1'b0; ifa.sof = 1'b0;
        ifb.din = '0; ifb.din_valid = 1'b0; ifb.sof = 1'b0;
        tick();
        tick();
        chk("rst_a_dv",  ifa.dout_valid, 1'b0);
        chk("rst_a_fd",  ifa.frame_done, 1'b0);
        chk("rst_a_win", ifa.win_o, '0);
        chk("rst_a_x",   ifa.x_o, '0);
        chk("rst_a_y",   ifa.y_o, '0);
        chk("rst_b_dv",  ifb.dout_valid, 1'b0);
        chk("rst_b_win", ifb.win_o[511:0], '0);
        chk("rst_b_xy",  {ifb.x_o, ifb.y_o}, '0);
        rst = 1'b0;

        frame_a(0, 1'b0, 1'b1, p, d);
        chk("t1_pulses", p, 4);
        chk("t1_done", d, 1);

        frame_a(16, 1'b1, 1'b1, p, d);
        chk("t2_pulses", p, 4);
        chk("t2_done", d, 1);

        partial_a(32, 6);
        frame_a(80, 1'b0, 1'b1, p, d);
        chk("t3_pulses", p, 4);
        chk("t3_done", d, 1);

        partial_a(48, 10);
        rst = 1'b1;
        ifa.din_valid = 1'b1;
        ifa.sof       = 1'b1;
        ifa.din       = 8'hFF;
        tick();
        rst = 1'b0;
        ifa.din_valid = 1'b0;
        ifa.sof       = 1'b0;
        chk("t4_dv",  ifa.dout_valid, 1'b0);
        chk("t4_fd",  ifa.frame_done, 1'b0);
        chk("t4_win", ifa.win_o, '0);
        chk("t4_xy",  {ifa.x_o, ifa.y_o}, '0);
        frame_a(64, 1'b0, 1'b0, p, d);
        chk("t4_pulses", p, 4);
        chk("t4_done", d, 1);

        frame_b(p, d);
        chk("t5_pulses", p, 26 * 18);
        chk("t5_done", d, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
